// File: rtl/ghost_controller_if.sv
// Maze wall-lookup bus between the ghost controller (master) and the maze map (slave).
interface ghost_controller_if;
  logic       query_req;
  logic [4:0] query_x;
  logic [4:0] query_y;
  logic       query_wall;

  modport master (output query_req, output query_x, output query_y, input query_wall);
  modport slave  (input query_req, input query_x, input query_y, output query_wall);
endinterface

// File: rtl/ghost_controller.sv
// Tile-grid chase engine for one ghost: probes up to four neighbour tiles per tick,
// steps onto the first clear one, and latches a sticky gameover on collision.
module ghost_controller #(
  parameter int unsigned COLS    = 25,
  parameter int unsigned ROWS    = 22,
  parameter int unsigned START_X = 12,
  parameter int unsigned START_Y = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic [4:0]         pac_x,
  input  logic [4:0]         pac_y,
  ghost_controller_if.master maze,
  output logic [4:0]         ghost_x,
  output logic [4:0]         ghost_y,
  output logic [1:0]         dir,
  output logic               busy,
  output logic               gameover
);

  localparam int unsigned TW = 5;
  localparam int unsigned NW = TW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROBE = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MOVE  = 3'd3;
  localparam logic [2:0] S_DEAD  = 3'd4;

  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_UP    = 2'd3;

  // Direction of the k-th candidate; flipping bit 0 gives the opposite direction.
  function automatic logic [1:0] cand_dir(input logic [TW-1:0] tx, input logic [TW-1:0] ty,
                                          input logic [TW-1:0] gx, input logic [TW-1:0] gy,
                                          input logic [1:0] k);
    logic [NW-1:0] dx, dy, ax, ay;
    logic [1:0]    h, v, d;
    dx = {1'b0, tx} - {1'b0, gx};
    dy = {1'b0, ty} - {1'b0, gy};
    ax = dx[NW-1] ? (NW'(0) - dx) : dx;
    ay = dy[NW-1] ? (NW'(0) - dy) : dy;
    h  = (tx > gx) ? D_RIGHT : D_LEFT;
    v  = (ty > gy) ? D_DOWN  : D_UP;
    if (ax >= ay) begin
      case (k)
        2'd0:    d = h;
        2'd1:    d = v;
        2'd2:    d = v ^ 2'd1;
        default: d = h ^ 2'd1;
      endcase
    end else begin
      case (k)
        2'd0:    d = v;
        2'd1:    d = h;
        2'd2:    d = h ^ 2'd1;
        default: d = v ^ 2'd1;
      endcase
    end
    return d;
  endfunction

  // Neighbour tile widened by one bit so that stepping below 0 shows up as out of range.
  function automatic logic [2*NW-1:0] neighbour(input logic [TW-1:0] gx, input logic [TW-1:0] gy,
                                                input logic [1:0] d);
    logic [NW-1:0] nx, ny;
    nx = {1'b0, gx};
    ny = {1'b0, gy};
    case (d)
      D_RIGHT: nx = nx + NW'(1);
      D_LEFT:  nx = nx - NW'(1);
      D_DOWN:  ny = ny + NW'(1);
      default: ny = ny - NW'(1);
    endcase
    return {nx, ny};
  endfunction

  logic [2:0]    r_state, w_state_n;
  logic [1:0]    r_k, w_k_n;
  logic [TW-1:0] r_tx, r_ty, r_gx, r_gy;
  logic [1:0]    r_dir;
  logic          r_busy, r_gameover, r_qreq;
  logic [TW-1:0] r_qx, r_qy;

  logic          w_collide, w_go_n, w_latch, w_move;
  logic [TW-1:0] w_tx, w_ty;
  logic [1:0]    w_cdir, w_ndir;
  logic [NW-1:0] w_cnx, w_cny, w_nnx, w_nny;
  logic          w_coob, w_noob, w_qreq_n;

  // Current candidate (for PROBE/MOVE) and the candidate the next cycle will probe.
  always_comb begin
    w_collide = (r_gx == pac_x) && (r_gy == pac_y);
    w_go_n    = r_gameover | w_collide;
    w_latch   = (r_state == S_IDLE) && tick;
    w_tx      = w_latch ? pac_x : r_tx;
    w_ty      = w_latch ? pac_y : r_ty;
    w_cdir    = cand_dir(r_tx, r_ty, r_gx, r_gy, r_k);
    {w_cnx, w_cny} = neighbour(r_gx, r_gy, w_cdir);
    w_coob    = (w_cnx >= NW'(COLS)) || (w_cny >= NW'(ROWS));
  end

  // Next-state logic; a collision overrides every other transition.
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_move    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tick) begin
          w_state_n = S_PROBE;
          w_k_n     = 2'd0;
        end
      end
      S_PROBE: begin
        if (!w_coob) begin
          w_state_n = S_CHECK;
        end else if (r_k == 2'd3) begin
          w_state_n = S_IDLE;
          w_k_n     = 2'd0;
        end else begin
          w_k_n = r_k + 2'd1;
        end
      end
      S_CHECK: begin
        if (!maze.query_wall) begin
          w_state_n = S_MOVE;
        end else if (r_k != 2'd3) begin
          w_state_n = S_PROBE;
          w_k_n     = r_k + 2'd1;
        end else begin
          w_state_n = S_IDLE;
          w_k_n     = 2'd0;
        end
      end
      S_MOVE: begin
        w_move    = 1'b1;
        w_state_n = S_IDLE;
        w_k_n     = 2'd0;
      end
      S_DEAD:  w_state_n = S_DEAD;
      default: begin
        w_state_n = S_IDLE;
        w_k_n     = 2'd0;
      end
    endcase
    if (w_go_n) begin
      w_state_n = S_DEAD;
      w_move    = 1'b0;
    end
  end

  // Lookup strobe is registered, so it is precomputed from the candidate of the next state.
  always_comb begin
    w_ndir = cand_dir(w_tx, w_ty, r_gx, r_gy, w_k_n);
    {w_nnx, w_nny} = neighbour(r_gx, r_gy, w_ndir);
    w_noob   = (w_nnx >= NW'(COLS)) || (w_nny >= NW'(ROWS));
    w_qreq_n = (w_state_n == S_PROBE) && !w_noob;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_k        <= 2'd0;
      r_tx       <= '0;
      r_ty       <= '0;
      r_gx       <= TW'(START_X);
      r_gy       <= TW'(START_Y);
      r_dir      <= D_RIGHT;
      r_busy     <= 1'b0;
      r_gameover <= 1'b0;
      r_qreq     <= 1'b0;
      r_qx       <= '0;
      r_qy       <= '0;
    end else begin
      r_state    <= w_state_n;
      r_k        <= w_k_n;
      r_gameover <= w_go_n;
      r_busy     <= (w_state_n != S_IDLE) && (w_state_n != S_DEAD);
      r_qreq     <= w_qreq_n;
      r_qx       <= w_qreq_n ? w_nnx[TW-1:0] : '0;
      r_qy       <= w_qreq_n ? w_nny[TW-1:0] : '0;
      if (w_latch) begin
        r_tx <= pac_x;
        r_ty <= pac_y;
      end
      if (w_move) begin
        r_gx  <= w_cnx[TW-1:0];
        r_gy  <= w_cny[TW-1:0];
        r_dir <= w_cdir;
      end
    end
  end

  assign ghost_x        = r_gx;
  assign ghost_y        = r_gy;
  assign dir            = r_dir;
  assign busy           = r_busy;
  assign gameover       = r_gameover;
  assign maze.query_req = r_qreq;
  assign maze.query_x   = r_qx;
  assign maze.query_y   = r_qy;

endmodule

// File: tb/tb_ghost_controller.sv
// Directed bench for ghost_controller: per-cycle vector table plus hand-written corner sequences.
module tb_ghost_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic [4:0] pac_x = 5'd20;
  logic [4:0] pac_y = 5'd10;
  logic [4:0] ghost_x, ghost_y;
  logic [1:0] dir;
  logic       busy, gameover;
  logic [1:0] mode = 2'd0;
  logic       r_wall = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  logic [9:0] qlog[$];

  ghost_controller_if mz();
  assign mz.query_wall = r_wall;

  ghost_controller #(.COLS(25), .ROWS(22), .START_X(12), .START_Y(10)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .pac_x(pac_x), .pac_y(pac_y),
    .maze(mz.master), .ghost_x(ghost_x), .ghost_y(ghost_y), .dir(dir),
    .busy(busy), .gameover(gameover)
  );

  always #5 clk = ~clk;

  // Maze model: 0 open, 1 walls at (13,10) and (12,11), 2 every tile a wall.
  function automatic logic is_wall(input logic [4:0] x, input logic [4:0] y);
    case (mode)
      2'd1:    return ((x == 5'd13) && (y == 5'd10)) || ((x == 5'd12) && (y == 5'd11));
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) r_wall <= mz.query_req && is_wall(mz.query_x, mz.query_y);

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic        tick;
    logic [4:0]  px;
    logic [4:0]  py;
    logic [24:0] exp;
  } vec_t;

  function automatic logic [24:0] pk(input logic q, input logic [4:0] qx, input logic [4:0] qy,
                                     input logic [4:0] gx, input logic [4:0] gy, input logic [1:0] d,
                                     input logic b, input logic g);
    return {q, qx, qy, gx, gy, d, b, g};
  endfunction

  function automatic logic [24:0] outs();
    return {mz.query_req, mz.query_x, mz.query_y, ghost_x, ghost_y, dir, busy, gameover};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input logic [4:0] px, input logic [4:0] py);
    @(negedge clk);
    reset_n = 1'b0;
    tick    = 1'b0;
    pac_x   = px;
    pac_y   = py;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Pulse tick, log lookups, return the edge count (from the tick edge) at which busy drops.
  task automatic do_tick(output int edges);
    int cyc;
    qlog.delete();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    cyc = 1;
    while (busy && cyc < 40) begin
      if (mz.query_req) qlog.push_back({mz.query_x, mz.query_y});
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) begin
      n_chk++;
      n_err++;
      $display("FAIL do_tick_timeout: busy still %0b after %0d cycles", busy, cyc);
    end
    edges = cyc - 1;
  endtask

  vec_t vt[12];
  int   edges;
  int   nq;

  initial begin
    vt[0]  = '{1'b1, 2'd0, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 12, 10, 0, 0, 0)};
    vt[1]  = '{1'b0, 2'd0, 1'b1, 5'd20, 5'd10, pk(1, 13, 10, 12, 10, 0, 1, 0)};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 5'd20, 5'd10, pk(0, 0, 0, 12, 10, 0, 1, 0)};
    vt[3]  = '{1'b0, 2'd0, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 12, 10, 0, 1, 0)};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 13, 10, 0, 0, 0)};
    vt[5]  = '{1'b0, 2'd0, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 13, 10, 0, 0, 0)};
    vt[6]  = '{1'b1, 2'd1, 1'b1, 5'd20, 5'd10, pk(1, 13, 10, 12, 10, 0, 1, 0)};
    vt[7]  = '{1'b0, 2'd1, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 12, 10, 0, 1, 0)};
    vt[8]  = '{1'b0, 2'd1, 1'b0, 5'd20, 5'd10, pk(1, 12, 9, 12, 10, 0, 1, 0)};
    vt[9]  = '{1'b0, 2'd1, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 12, 10, 0, 1, 0)};
    vt[10] = '{1'b0, 2'd1, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 12, 10, 0, 1, 0)};
    vt[11] = '{1'b0, 2'd1, 1'b0, 5'd20, 5'd10, pk(0, 0, 0, 12, 9, 3, 0, 0)};

    // Open-maze single step and wall-steered step, one row per clock edge.
    for (int i = 0; i < 12; i++) begin
      if (vt[i].rst) apply_reset(vt[i].px, vt[i].py);
      mode = vt[i].mode;
      @(negedge clk);
      tick  = vt[i].tick;
      pac_x = vt[i].px;
      pac_y = vt[i].py;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end
    tick = 1'b0;

    // Walk the ghost to the left edge at (0,5).
    mode = 2'd0;
    apply_reset(5'd12, 5'd0);
    repeat (5) do_tick(edges);
    chk("walk_up", {22'd0, ghost_x, ghost_y}, {22'd0, 5'd12, 5'd5});
    pac_x = 5'd0;
    pac_y = 5'd6;
    repeat (12) do_tick(edges);
    chk("walk_left", {22'd0, ghost_x, ghost_y}, {22'd0, 5'd0, 5'd5});

    // All walls at the left border: left candidate skipped with no lookup.
    mode  = 2'd2;
    pac_x = 5'd0;
    pac_y = 5'd0;
    do_tick(edges);
    nq = qlog.size();
    chk("edge_edges", 32'(edges), 32'd7);
    chk("edge_nq", 32'(nq), 32'd3);
    if (nq == 3) begin
      chk("edge_q0", 32'(qlog[0]), 32'({5'd0, 5'd4}));
      chk("edge_q1", 32'(qlog[1]), 32'({5'd1, 5'd5}));
      chk("edge_q2", 32'(qlog[2]), 32'({5'd0, 5'd6}));
    end
    chk("edge_stay", {21'd0, busy, ghost_x, ghost_y}, {21'd0, 1'b0, 5'd0, 5'd5});

    // Pac steps onto the idle ghost; gameover is sticky and ticks are ignored.
    @(negedge clk);
    pac_x = 5'd0;
    pac_y = 5'd5;
    chk("go_before", 32'(gameover), 32'd0);
    @(negedge clk);
    chk("go_after", {30'd0, gameover, busy}, {30'd0, 1'b1, 1'b0});
    nq = 0;
    for (int t = 0; t < 2; t++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (mz.query_req || busy) nq++;
        @(negedge clk);
      end
    end
    chk("dead_quiet", 32'(nq), 32'd0);
    chk("dead_pos", {21'd0, gameover, ghost_x, ghost_y}, {21'd0, 1'b1, 5'd0, 5'd5});

    // Collision while waiting on the lookup abandons the move.
    mode = 2'd0;
    apply_reset(5'd20, 5'd10);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    chk("chk_busy", {31'd0, busy}, 32'd1);
    pac_x = 5'd12;
    pac_y = 5'd10;
    @(negedge clk);
    chk("chk_go", {20'd0, gameover, busy, ghost_x, ghost_y}, {20'd0, 1'b1, 1'b0, 5'd12, 5'd10});
    repeat (4) @(negedge clk);
    chk("chk_frozen", {19'd0, gameover, dir, ghost_x, ghost_y}, {19'd0, 1'b1, 2'd0, 5'd12, 5'd10});

    // Reset in the middle of a probe after one completed move.
    apply_reset(5'd20, 5'd10);
    do_tick(edges);
    chk("pre_move", {22'd0, ghost_x, ghost_y}, {22'd0, 5'd13, 5'd10});
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk("mid_probe", {31'd0, mz.query_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'(pk(0, 0, 0, 12, 10, 0, 0, 0)));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_tick(edges);
    chk("restart_edges", 32'(edges), 32'd3);
    chk("restart_pos", {20'd0, dir, ghost_x, ghost_y}, {20'd0, 2'd0, 5'd13, 5'd10});
    if (qlog.size() == 1) chk("restart_q", 32'(qlog[0]), 32'({5'd13, 5'd10}));
    else chk("restart_nq", 32'(qlog.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
